term_esc_decoder: RTL and testbench



---
 rtl/esc_pkg.sv | 23 ++
 rtl/csi_param_acc.sv | 42 ++++
 rtl/term_esc_decoder.sv | 195 +++++++++++++++++++
 tb/tb_term_esc_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/esc_pkg.sv
// esc_pkg: shared constants for the terminal escape-sequence decoder.
//   - FSM state encoding: ST_GROUND, ST_ESC, ST_CSI, ST_CLEAR
//   - ASCII constants used by the parser
//   - default screen geometry
package esc_pkg;
    localparam logic [1:0] ST_GROUND = 2'd0;
    localparam logic [1:0] ST_ESC    = 2'd1;
    localparam logic [1:0] ST_CSI    = 2'd2;
    localparam logic [1:0] ST_CLEAR  = 2'd3;

    localparam logic [7:0] ASCII_ESC      = 8'h1B;
    localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
    localparam logic [7:0] ASCII_SEMI     = 8'h3B;
    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_CAN      = 8'h18;
    localparam logic [7:0] ASCII_SUB      = 8'h1A;
    localparam logic [7:0] ASCII_SPACE    = 8'h20;

    localparam int DEF_COLS = 40;
    localparam int DEF_ROWS = 25;
endpackage

// File: rtl/csi_param_acc.sv
// csi_param_acc: two 8-bit saturating decimal accumulators for CSI parameters.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-low reset
//   i_clr    in   zero both accumulators
//   i_idx    in   selects accumulator (0 = p0, 1 = p1) for the digit
//   i_dig_v  in   digit strobe
//   i_dig    in   decimal digit 0..9
//   o_p0     out  parameter 0
//   o_p1     out  parameter 1
module csi_param_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_idx,
    input  logic       i_dig_v,
    input  logic [3:0] i_dig,
    output logic [7:0] o_p0,
    output logic [7:0] o_p1
);
    logic [7:0]  r_p0, r_p1;
    logic [7:0]  w_cur, w_sat;
    logic [11:0] w_sum;

    // 255*10+9 fits in 12 bits, so any overflow shows up in the top nibble
    assign w_cur = i_idx ? r_p1 : r_p0;
    assign w_sum = {4'b0, w_cur} * 12'd10 + {8'b0, i_dig};
    assign w_sat = |w_sum[11:8] ? 8'hFF : w_sum[7:0];

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_p0 <= '0;
            r_p1 <= '0;
        end else if (i_dig_v) begin
            if (i_idx) r_p1 <= w_sat;
            else       r_p0 <= w_sat;
        end
    end

    assign o_p0 = r_p0;
    assign o_p1 = r_p1;
endmodule

// File: rtl/term_esc_decoder.sv
// term_esc_decoder: receive-side byte interpreter for the terminal link.
// Prints characters into the text buffer, handles CR/LF/BS and ANSI CSI
// cursor sequences (A/B/C/D/H/f), and keeps the linear cursor address.
// Optional: define CLEAR_SCREEN_EN to enable "ESC [ 2 J" full-screen clear.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-low reset
//   i_byte     in   received byte
//   i_byte_v   in   one-cycle strobe, i_byte valid
//   o_wen      out  text buffer write enable
//   o_waddr    out  text buffer write address
//   o_wdata    out  text buffer write data
//   o_cursor   out  cursor address row*COLS+col
//   o_busy     out  clear sweep in progress
//   o_overrun  out  pulse: byte dropped while busy
module term_esc_decoder
    import esc_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_byte_v,
    output logic       o_wen,
    output logic [9:0] o_waddr,
    output logic [7:0] o_wdata,
    output logic [9:0] o_cursor,
    output logic       o_busy,
    output logic       o_overrun
);
    localparam logic [9:0] LAST_COL = 10'(COLS - 1);
    localparam logic [9:0] LAST_ROW = 10'(ROWS - 1);
    localparam logic [9:0] COLS10   = 10'(COLS);

    logic [1:0] r_state, w_state_n;
    logic [9:0] r_row, r_col, w_row_n, w_col_n, w_row_inc;
    logic [9:0] r_cursor, r_waddr, w_waddr_n;
    logic [7:0] r_wdata, w_wdata_n;
    logic       r_wen, w_wen_n, r_idx;
    logic       w_clr, w_dig_v, w_semi;
    logic [7:0] w_p0, w_p1;
    logic [9:0] w_n, w_hr, w_hc;
    logic [10:0] w_dn, w_rt;

    csi_param_acc u_acc (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_idx   (r_idx),
        .i_dig_v (w_dig_v),
        .i_dig   (i_byte[3:0]),
        .o_p0    (w_p0),
        .o_p1    (w_p1)
    );

    // A zero parameter means 1 for both relative moves and absolute positions
    assign w_n       = w_p0 == 8'd0 ? 10'd1 : {2'b0, w_p0};
    assign w_hr      = (w_p0 == 8'd0 ? 10'd1 : {2'b0, w_p0}) - 10'd1;
    assign w_hc      = (w_p1 == 8'd0 ? 10'd1 : {2'b0, w_p1}) - 10'd1;
    assign w_dn      = {1'b0, r_row} + {1'b0, w_n};
    assign w_rt      = {1'b0, r_col} + {1'b0, w_n};
    assign w_row_inc = r_row == LAST_ROW ? 10'd0 : r_row + 10'd1;

`ifdef CLEAR_SCREEN_EN
    localparam logic [10:0] N_CELLS = 11'(ROWS * COLS);
    logic [10:0] r_clr_addr, w_clr_addr_n;
    logic        r_busy, r_overrun;
`endif

    always_comb begin
        w_state_n = r_state;
        w_row_n   = r_row;
        w_col_n   = r_col;
        w_wen_n   = 1'b0;
        w_waddr_n = r_waddr;
        w_wdata_n = r_wdata;
        w_clr     = 1'b0;
        w_dig_v   = 1'b0;
        w_semi    = 1'b0;
`ifdef CLEAR_SCREEN_EN
        w_clr_addr_n = r_clr_addr;
        if (r_state == ST_CLEAR) begin
            if (r_clr_addr == N_CELLS) begin
                w_state_n = ST_GROUND;
                w_row_n   = '0;
                w_col_n   = '0;
            end else begin
                w_wen_n      = 1'b1;
                w_waddr_n    = r_clr_addr[9:0];
                w_wdata_n    = ASCII_SPACE;
                w_clr_addr_n = r_clr_addr + 11'd1;
            end
        end else
`endif
        if (i_byte_v) begin
            case (r_state)
                ST_GROUND: begin
                    if (i_byte >= 8'h20 && i_byte <= 8'h7E) begin
                        w_wen_n   = 1'b1;
                        w_waddr_n = r_cursor;
                        w_wdata_n = i_byte;
                        w_col_n   = r_col == LAST_COL ? 10'd0 : r_col + 10'd1;
                        w_row_n   = r_col == LAST_COL ? w_row_inc : r_row;
                    end else if (i_byte == ASCII_CR) w_col_n = '0;
                    else if (i_byte == ASCII_LF) w_row_n = w_row_inc;
                    else if (i_byte == ASCII_BS) w_col_n = r_col == 10'd0 ? 10'd0 : r_col - 10'd1;
                    else if (i_byte == ASCII_ESC) w_state_n = ST_ESC;
                end
                ST_ESC: begin
                    w_clr     = i_byte == ASCII_LBRACKET;
                    w_state_n = i_byte == ASCII_LBRACKET ? ST_CSI :
                                i_byte == ASCII_ESC ? ST_ESC : ST_GROUND;
                end
                default: begin
                    if (i_byte >= 8'h30 && i_byte <= 8'h39) w_dig_v = 1'b1;
                    else if (i_byte == ASCII_SEMI) w_semi = 1'b1;
                    else if (i_byte == ASCII_CAN || i_byte == ASCII_SUB) w_state_n = ST_GROUND;
                    else if (i_byte == ASCII_ESC) w_state_n = ST_ESC;
                    else if (i_byte >= 8'h40 && i_byte <= 8'h7E) begin
                        w_state_n = ST_GROUND;
                        case (i_byte)
                            8'h41: w_row_n = r_row > w_n ? r_row - w_n : 10'd0;
                            8'h42: w_row_n = w_dn > {1'b0, LAST_ROW} ? LAST_ROW : w_dn[9:0];
                            8'h43: w_col_n = w_rt > {1'b0, LAST_COL} ? LAST_COL : w_rt[9:0];
                            8'h44: w_col_n = r_col > w_n ? r_col - w_n : 10'd0;
                            8'h48, 8'h66: begin
                                w_row_n = w_hr > LAST_ROW ? LAST_ROW : w_hr;
                                w_col_n = w_hc > LAST_COL ? LAST_COL : w_hc;
                            end
`ifdef CLEAR_SCREEN_EN
                            8'h4A: if (w_p0 == 8'd2) begin
                                w_state_n    = ST_CLEAR;
                                w_wen_n      = 1'b1;
                                w_waddr_n    = '0;
                                w_wdata_n    = ASCII_SPACE;
                                w_clr_addr_n = 11'd1;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_GROUND;
            r_row    <= '0;
            r_col    <= '0;
            r_cursor <= '0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_idx    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_row    <= w_row_n;
            r_col    <= w_col_n;
            // Computed from next row/col so the cursor moves with the write strobe
            r_cursor <= w_row_n * COLS10 + w_col_n;
            r_wen    <= w_wen_n;
            r_waddr  <= w_waddr_n;
            r_wdata  <= w_wdata_n;
            r_idx    <= w_clr ? 1'b0 : (w_semi ? 1'b1 : r_idx);
        end
    end

`ifdef CLEAR_SCREEN_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clr_addr <= '0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_clr_addr <= w_clr_addr_n;
            r_busy     <= w_state_n == ST_CLEAR;
            r_overrun  <= i_byte_v && r_state == ST_CLEAR;
        end
    end
    assign o_busy    = r_busy;
    assign o_overrun = r_overrun;
`else
    assign o_busy    = 1'b0;
    assign o_overrun = 1'b0;
`endif

    assign o_wen    = r_wen;
    assign o_waddr  = r_waddr;
    assign o_wdata  = r_wdata;
    assign o_cursor = r_cursor;
endmodule

// File: tb/tb_term_esc_decoder.sv
// tb_term_esc_decoder: directed and random checks of term_esc_decoder against a screen model.
module tb_term_esc_decoder;
    localparam int COLS = 40;
    localparam int ROWS = 25;
    localparam int N    = COLS * ROWS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       i_byte_v = 1'b0;
    logic       o_wen, o_busy, o_overrun;
    logic [9:0] o_waddr, o_cursor;
    logic [7:0] o_wdata;

    term_esc_decoder #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_byte    (i_byte),
        .i_byte_v  (i_byte_v),
        .o_wen     (o_wen),
        .o_waddr   (o_waddr),
        .o_wdata   (o_wdata),
        .o_cursor  (o_cursor),
        .o_busy    (o_busy),
        .o_overrun (o_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Screen model: plain integers and a parser mode, nothing register-level
    int m_row, m_col, m_mode, m_idx;
    int m_p[2];
    bit m_wen, m_clear;
    int m_addr, m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_row = 0; m_col = 0; m_mode = 0; m_idx = 0;
        m_p[0] = 0; m_p[1] = 0;
        m_wen = 0; m_clear = 0;
    endfunction

    function automatic int imin(input int a, input int b);
        return a < b ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return a > b ? a : b;
    endfunction

    function automatic void model(input logic [7:0] b);
        int n;
        m_wen = 0;
        m_clear = 0;
        if (m_mode == 0) begin
            if (b >= 8'h20 && b <= 8'h7E) begin
                m_wen = 1; m_addr = m_row * COLS + m_col; m_data = b;
                m_col++;
                if (m_col == COLS) begin m_col = 0; m_row = (m_row + 1) % ROWS; end
            end else if (b == 8'h0D) m_col = 0;
            else if (b == 8'h0A) m_row = (m_row + 1) % ROWS;
            else if (b == 8'h08) m_col = imax(m_col - 1, 0);
            else if (b == 8'h1B) m_mode = 1;
        end else if (m_mode == 1) begin
            if (b == "[") begin m_mode = 2; m_p[0] = 0; m_p[1] = 0; m_idx = 0; end
            else if (b != 8'h1B) m_mode = 0;
        end else begin
            n = m_p[0] == 0 ? 1 : m_p[0];
            if (b >= "0" && b <= "9") m_p[m_idx] = imin(m_p[m_idx] * 10 + int'(b - "0"), 255);
            else if (b == ";") m_idx = 1;
            else if (b == 8'h18 || b == 8'h1A) m_mode = 0;
            else if (b == 8'h1B) m_mode = 1;
            else if (b >= 8'h40 && b <= 8'h7E) begin
                m_mode = 0;
                if (b == "A") m_row = imax(m_row - n, 0);
                else if (b == "B") m_row = imin(m_row + n, ROWS - 1);
                else if (b == "C") m_col = imin(m_col + n, COLS - 1);
                else if (b == "D") m_col = imax(m_col - n, 0);
                else if (b == "H" || b == "f") begin
                    m_row = imin(n - 1, ROWS - 1);
                    m_col = imin((m_p[1] == 0 ? 1 : m_p[1]) - 1, COLS - 1);
                end
`ifdef CLEAR_SCREEN_EN
                else if (b == "J" && m_p[0] == 2) begin
                    m_clear = 1; m_wen = 1; m_addr = 0; m_data = 32;
                    m_row = 0; m_col = 0;
                end
`endif
            end
        end
    endfunction

`ifdef CLEAR_SCREEN_EN
    task automatic sweep();
        bit poke;
        for (int a = 1; a < N; a++) begin
            poke = (a == N / 2);
            if (poke) begin i_byte = 8'h41; i_byte_v = 1'b1; end
            @(negedge clk);
            i_byte_v = 1'b0;
            chk("clr_wen", o_wen, 1);
            chk("clr_addr", o_waddr, a);
            chk("clr_data", o_wdata, 8'h20);
            chk("clr_busy", o_busy, 1);
            chk("clr_overrun", o_overrun, poke);
        end
        @(negedge clk);
        chk("clr_end_busy", o_busy, 0);
        chk("clr_end_wen", o_wen, 0);
        chk("clr_end_cursor", o_cursor, 0);
        chk("clr_end_overrun", o_overrun, 0);
    endtask
`endif

    // Called at a negedge; returns at the following negedge after checking
    task automatic send(input logic [7:0] b);
        i_byte = b;
        i_byte_v = 1'b1;
        model(b);
        @(negedge clk);
        i_byte_v = 1'b0;
        chk("wen", o_wen, m_wen);
        if (m_wen) begin
            chk("waddr", o_waddr, m_addr);
            chk("wdata", o_wdata, m_data);
        end
        chk("busy", o_busy, m_clear);
        chk("overrun", o_overrun, 0);
        if (!m_clear) chk("cursor", o_cursor, m_row * COLS + m_col);
`ifdef CLEAR_SCREEN_EN
        if (m_clear) sweep();
`endif
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    function automatic logic [7:0] pick();
        int r;
        string fin;
        fin = "ABCDHfm";
        r = $urandom_range(0, 99);
        if (r < 40) return 8'($urandom_range(32, 126));
        if (r < 50) return 8'h1B;
        if (r < 60) return "[";
        if (r < 72) return 8'($urandom_range(48, 57));
        if (r < 77) return ";";
        if (r < 87) return fin[$urandom_range(0, 6)];
        if (r < 95) begin
            case ($urandom_range(0, 5))
                0: return 8'h0D;
                1: return 8'h0A;
                2: return 8'h08;
                3: return 8'h18;
                4: return 8'h1A;
                default: return 8'h00;
            endcase
        end
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_wen", o_wen, 0);
        chk("rst_waddr", o_waddr, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_cursor", o_cursor, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_overrun", o_overrun, 0);
        rst = 1'b1;
        @(negedge clk);

        send("A");
        chk("plan_A_addr", o_waddr, 0);
        chk("plan_A_data", o_wdata, 8'h41);
        chk("plan_A_cursor", o_cursor, 1);
        send(8'h1B); send_str("[5;10H");
        chk("plan_169", o_cursor, 169);
        send(8'h1B); send_str("[3D");
        chk("plan_166", o_cursor, 166);
        send(8'h1B); send_str("[H");
        chk("plan_home", o_cursor, 0);
        send(8'h1B); send_str("[999B");
        chk("plan_960", o_cursor, 960);
        send(8'h1B); send_str("[A");
        chk("plan_920", o_cursor, 920);
        send(8'h1B); send_str("[25;40H");
        chk("plan_999", o_cursor, 999);
        send("Z");
        chk("plan_Z_addr", o_waddr, 999);
        chk("plan_Z_data", o_wdata, 8'h5A);
        chk("plan_wrap", o_cursor, 0);
        send(8'h0D); send(8'h0A); send(8'h08);
        chk("plan_40", o_cursor, 40);
        send(8'h1B); send_str("[99C");
        chk("plan_right_clamp", o_cursor, 79);
        send(8'h1B); send_str("[0;0f");
        chk("plan_f_zero", o_cursor, 0);

`ifdef CLEAR_SCREEN_EN
        send_str("hi");
        send(8'h1B); send_str("[2J");
        send(8'h1B); send_str("[3J");
        chk("plan_J3_ignored", o_wen, 0);
`else
        send(8'h1B); send_str("[2J");
        chk("plan_J_ignored", o_busy, 0);
`endif

        send(8'h1B); send_str("[12");
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        chk("midrst_cursor", o_cursor, 0);
        chk("midrst_wen", o_wen, 0);
        send("5");
        chk("midrst_addr", o_waddr, 0);
        chk("midrst_data", o_wdata, 8'h35);
        send(8'h1B); send_str("[3"); send(8'h18); send("x");
        chk("can_addr", o_waddr, 1);
        chk("can_data", o_wdata, 8'h78);

        for (int i = 0; i < 600; i++) begin
            send(pick());
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                chk("idle_wen", o_wen, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
